// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: generic inter-stage pipeline register with valid/ready
// handshake, optional one-entry skid buffer, synchronous flush that inserts
// a bubble, and a saturating stall counter.
module pipe_stage_buffer #(
   parameter int DATA_W = 102,
   parameter int CTRL_W = 5,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              r_in_ready;

   logic              w_out_valid;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_emit;
   logic              w_load_main_in;
   logic              w_load_main_skid;
   logic              w_load_skid;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   // Handshake decode; without a skid entry in_ready must look through to out_ready.
   always_comb begin
      w_out_valid = (r_state != ST_EMPTY);
      w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
      w_accept    = in_valid && w_in_ready;
      w_emit      = w_out_valid && out_ready;
   end

   // Next-state and storage-load decode; flush overrides accept and emit.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt    = ST_BUSY;
                  w_load_main_in = 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_accept && w_emit) begin
                  w_load_main_in = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_load_skid = 1'b1;
               end else if (w_emit) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_emit) begin
                  w_state_nxt      = ST_BUSY;
                  w_load_main_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // State register plus registered in_ready (low only while both entries are held).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Payload storage; flush leaves stale data in place since out_valid masks it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
         end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
         end
         if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end
   end

   // Stall counter: counts held-but-not-taken cycles, saturating, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_ready && !flush) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   // Output drive; control is masked so a bubble never raises downstream enables.
   always_comb begin
      in_ready  = w_in_ready;
      out_valid = w_out_valid;
      out_data  = r_main_data;
      out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
      stall_cnt = r_stall_cnt;
   end

endmodule
